// File: rtl/hdc_pkg.sv
// Shared types and default geometry for the HDC class hypervector store.
package hdc_pkg;

    localparam int NUM_CLASSES      = 4;
    localparam int SEQ_CYCLE_COUNT  = 4;
    localparam int DIMS_PER_CC      = 1024;
    localparam int BITWIDTH_PER_DIM = 9;

    // One segment of a class HV: DIMS_PER_CC signed dims.
    typedef logic [DIMS_PER_CC-1:0][BITWIDTH_PER_DIM-1:0] seg_t;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_ADD   = 2'd1,
        OP_SUB   = 2'd2,
        OP_CLEAR = 2'd3
    } cmd_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } store_state_e;

    // True when an index addresses a real entry (matters for non-power-of-2 sizes).
    function automatic logic idx_in_range(int idx, int limit);
        return idx < limit;
    endfunction

endpackage

// File: rtl/hv_sat_addsub.sv
// Combinational per-segment +/-1 saturating updater for bipolar (de)accumulation.
module hv_sat_addsub #(
    parameter int DIMS = hdc_pkg::DIMS_PER_CC,
    parameter int BW   = hdc_pkg::BITWIDTH_PER_DIM
) (
    input  logic [DIMS-1:0][BW-1:0] seg_in,
    input  logic [DIMS-1:0]         query,
    input  logic                    sub,
    output logic [DIMS-1:0][BW-1:0] seg_out,
    output logic                    any_sat
);

    localparam logic [BW-1:0] MAX_V = {1'b0, {(BW-1){1'b1}}};
    localparam logic [BW-1:0] MIN_V = {1'b1, {(BW-1){1'b0}}};

    // Step each dim toward +1 when (query bit XOR sub) is set, else toward -1; clip at the rails.
    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        seg_out = seg_in;
        any_sat = 1'b0;
        for (int d = 0; d < DIMS; d++) begin
            if (query[d] ^ sub) begin
                if (seg_in[d] == MAX_V) any_sat = 1'b1;
                else                    seg_out[d] = seg_in[d] + BW'(1);
            end else begin
                if (seg_in[d] == MIN_V) any_sat = 1'b1;
                else                    seg_out[d] = seg_in[d] - BW'(1);
            end
        end
    end

endmodule

// File: rtl/class_hv_store.sv
// Class hypervector store: segment write, saturating ADD/SUB, CLEAR_ALL sweep, registered read.
module class_hv_store #(
    parameter  int NUM_CLASSES      = hdc_pkg::NUM_CLASSES,
    parameter  int SEQ_CYCLE_COUNT  = hdc_pkg::SEQ_CYCLE_COUNT,
    parameter  int DIMS_PER_CC      = hdc_pkg::DIMS_PER_CC,
    parameter  int BITWIDTH_PER_DIM = hdc_pkg::BITWIDTH_PER_DIM,
    localparam int CLASS_W  = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
    localparam int SEG_W    = (SEQ_CYCLE_COUNT > 1) ? $clog2(SEQ_CYCLE_COUNT) : 1,
    localparam int SEG_BITS = DIMS_PER_CC * BITWIDTH_PER_DIM
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [CLASS_W-1:0]  cmd_class,
    input  logic [SEG_W-1:0]    cmd_seg,
    input  logic [SEG_BITS-1:0] cmd_data,
    input  logic [DIMS_PER_CC-1:0] cmd_query,
    input  logic                rd_en,
    input  logic [CLASS_W-1:0]  rd_class,
    input  logic [SEG_W-1:0]    rd_seg,
    output logic [SEG_BITS-1:0] rd_data,
    output logic                rd_valid,
    output logic                sat_event,
    output logic                clear_busy
);

    import hdc_pkg::*;

    typedef logic [DIMS_PER_CC-1:0][BITWIDTH_PER_DIM-1:0] entry_t;

    entry_t [NUM_CLASSES-1:0][SEQ_CYCLE_COUNT-1:0] mem_q;

    store_state_e       state_q, state_d;
    logic [CLASS_W-1:0] clr_class_q, clr_class_d;
    logic [SEG_W-1:0]   clr_seg_q, clr_seg_d;
    logic               sat_event_q, sat_event_d;
    logic               rd_valid_q, rd_valid_d;
    entry_t             rd_data_q, rd_data_d;

    logic               cmd_ok, rd_ok, is_sub, upd_sat;
    entry_t             upd_src, upd_res;
    logic               wr_en;
    logic [CLASS_W-1:0] wr_class;
    logic [SEG_W-1:0]   wr_seg;
    entry_t             wr_data;

    assign cmd_ok = idx_in_range(int'(cmd_class), NUM_CLASSES) &&
                    idx_in_range(int'(cmd_seg), SEQ_CYCLE_COUNT);
    assign rd_ok  = idx_in_range(int'(rd_class), NUM_CLASSES) &&
                    idx_in_range(int'(rd_seg), SEQ_CYCLE_COUNT);
    assign is_sub  = (cmd_op_e'(cmd_op) == OP_SUB);
    assign upd_src = cmd_ok ? mem_q[cmd_class][cmd_seg] : '0;

    hv_sat_addsub #(
        .DIMS (DIMS_PER_CC),
        .BW   (BITWIDTH_PER_DIM)
    ) u_addsub (
        .seg_in  (upd_src),
        .query   (cmd_query),
        .sub     (is_sub),
        .seg_out (upd_res),
        .any_sat (upd_sat)
    );

    // Next-state, handshake and single write-port selection (command in IDLE, sweep in CLEAR).
    always_comb begin
        state_d     = state_q;
        clr_class_d = clr_class_q;
        clr_seg_d   = clr_seg_q;
        sat_event_d = 1'b0;
        cmd_ready   = 1'b0;
        clear_busy  = 1'b0;
        wr_en       = 1'b0;
        wr_class    = cmd_class;
        wr_seg      = cmd_seg;
        wr_data     = cmd_data;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = nrst;
                if (cmd_valid && nrst) begin
                    case (cmd_op_e'(cmd_op))
                        OP_WRITE: wr_en = cmd_ok;
                        OP_ADD, OP_SUB: begin
                            wr_en       = cmd_ok;
                            wr_data     = upd_res;
                            sat_event_d = cmd_ok && upd_sat;
                        end
                        OP_CLEAR: begin
                            state_d     = ST_CLEAR;
                            clr_class_d = '0;
                            clr_seg_d   = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_CLEAR: begin
                clear_busy = 1'b1;
                wr_en      = 1'b1;
                wr_class   = clr_class_q;
                wr_seg     = clr_seg_q;
                wr_data    = '0;
                if (clr_seg_q == SEG_W'(SEQ_CYCLE_COUNT - 1)) begin
                    clr_seg_d = '0;
                    if (clr_class_q == CLASS_W'(NUM_CLASSES - 1)) state_d = ST_IDLE;
                    else clr_class_d = clr_class_q + CLASS_W'(1);
                end else begin
                    clr_seg_d = clr_seg_q + SEG_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read port samples current contents, so a same-cycle update is seen only on the next read.
    always_comb begin
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        if (rd_en) rd_data_d = rd_ok ? mem_q[rd_class][rd_seg] : '0;
    end

    // Control and read-port registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (!nrst) begin
            state_q     <= ST_IDLE;
            clr_class_q <= '0;
            clr_seg_q   <= '0;
            sat_event_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            clr_class_q <= clr_class_d;
            clr_seg_q   <= clr_seg_d;
            sat_event_q <= sat_event_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Storage array: one entry written per cycle; reset (even mid-sweep) leaves it all-zero.
    always_ff @(posedge clk) begin
        // NOTE: the array is flop-based and reset, which rules out mapping it onto a RAM macro.
        if (!nrst)      mem_q <= '0;
        else if (wr_en) mem_q[wr_class][wr_seg] <= wr_data;
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign sat_event = sat_event_q;

endmodule
